// File: rtl/conv_window_generator.sv
// Raster-scan 3x3 window generator: two line buffers plus a 3-column shift register.
// Emits one packed window per pixel at (r>=2, c>=2) through a single registered output stage.
module conv_window_generator #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32,
    parameter int unsigned PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic [9*PIX_W-1:0]       win_data,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned P  = PIX_W;

    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

    state_e state_q, state_d;
    logic   frame_done_d;

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2 at the current column.
    logic [P-1:0] lb0_q [IMG_W];
    logic [P-1:0] lb1_q [IMG_W];

    // Older window columns, each packed {top, mid, bot}; sr0 is the leftmost.
    logic [3*P-1:0] sr0_q, sr1_q;
    logic [3*P-1:0] col_word;
    logic [9*P-1:0] win_next;

    logic out_free, accept, col_last, last_pix, in_window;

    assign out_free  = !win_valid || win_ready;
    assign pix_ready = (state_q == StActive) && out_free;
    assign accept    = pix_valid && pix_ready;
    assign col_last  = (col_q == ColLast);
    assign last_pix  = col_last && (row_q == RowLast);
    assign in_window = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign col_word  = {lb1_q[col_q], lb0_q[col_q], pix_data};

    // Top row first, left to right; bottom-right pixel in the LSBs.
    assign win_next = {sr0_q[3*P-1 -: P], sr1_q[3*P-1 -: P], col_word[3*P-1 -: P],
                       sr0_q[2*P-1 -: P], sr1_q[2*P-1 -: P], col_word[2*P-1 -: P],
                       sr0_q[P-1:0],      sr1_q[P-1:0],      col_word[P-1:0]};

    // Frame sequencing next-state and end-of-frame pulse.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle:   if (frame_start) state_d = StActive;
            StActive: if (accept && last_pix) state_d = StDrain;
            StDrain: begin
                if (out_free) begin
                    state_d      = StIdle;
                    frame_done_d = 1'b1;
                end
            end
            default:  state_d = StIdle;
        endcase
    end

    // State register and registered frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= frame_done_d;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state_q == StIdle && frame_start) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Line buffers and column shift register; never read before written within a frame.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= pix_data;
            sr0_q        <= sr1_q;
            sr1_q        <= col_word;
        end
    end

    // Output stage: load on a windowing accept, hold while stalled, clear on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (accept) begin
            win_valid <= in_window;
            if (in_window) begin
                win_data <= win_next;
                win_row  <= row_q - RW'(2);
                win_col  <= col_q - CW'(2);
            end
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_generator.sv
// Self-checking bench for conv_window_generator on a 5x5 image.
module tb_conv_window_generator;

    localparam int W     = 5;
    localparam int H     = 5;
    localparam int NPIX  = W * H;
    localparam int TOTAL = (H - 2) * (W - 2);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [2:0]  win_row;
    logic [2:0]  win_col;
    logic        frame_done;

    conv_window_generator #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_data    (win_data),
        .win_row     (win_row),
        .win_col     (win_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] data;
        int          row;
        int          col;
    } win_t;

    typedef struct {
        string       name;
        int          vmode;   // 0 always valid, 1 toggle 1010.., 2 random
        int          rmode;   // 0 always ready, 1 random
        int          stall;   // cycles of win_ready=0 at the first window
        bit          mid;     // pulse frame_start mid-frame
        int          exp_n;
        logic [71:0] exp_first;
        logic [71:0] exp_last;
    } vec_t;

    logic [7:0] img [H][W];
    win_t       exp_q [$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = {r[3:0], c[3:0]};
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    // Reference: every 3x3 neighbourhood fully inside the image, raster order.
    task automatic build_expected();
        win_t w;
        exp_q.delete();
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                w.data = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                          img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                          img[r][c-2],   img[r][c-1],   img[r][c]};
                w.row  = r - 2;
                w.col  = c - 2;
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run_frame(input int vmode, input int rmode, input int stall_first,
                             input bit mid_start, input int abort_after,
                             output int nwin, output logic [71:0] first_w,
                             output logic [71:0] last_w);
        int          idx, cyc, done_cnt, stall_left, r, c;
        bit          tog, vbit, exp_valid, held, acc;
        logic [71:0] held_data;
        win_t        w;
        idx = 0; cyc = 0; done_cnt = 0; tog = 1'b1; exp_valid = 1'b0; held = 1'b0;
        held_data = '0; nwin = 0; first_w = '0; last_w = '0; stall_left = stall_first;
        build_expected();
        @(negedge clk);
        frame_start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (cyc < 2000) begin
            vbit = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            tog  = !tog;
            pix_valid = (idx < NPIX) && vbit;
            pix_data  = (idx < NPIX && vbit) ? img[idx / W][idx % W] : 8'($urandom);
            if (exp_valid && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            frame_start = mid_start && (idx == 12);
            #1;
            chk("win_valid", win_valid, exp_valid);
            chk("pix_ready", pix_ready, (idx < NPIX) && (!exp_valid || win_ready));
            if (held) chk("held_data", win_data, held_data);
            if (frame_done) begin
                done_cnt++;
                chk("frame_done_windows", nwin, TOTAL);
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_window", 1'b1, 1'b0);
                end else begin
                    w = exp_q.pop_front();
                    chk("win_data", win_data, w.data);
                    chk("win_row", win_row, w.row);
                    chk("win_col", win_col, w.col);
                end
                if (nwin == 0) first_w = win_data;
                last_w = win_data;
                nwin++;
            end
            acc = pix_valid && pix_ready;
            if (acc) begin
                r = idx / W;
                c = idx % W;
                idx++;
                exp_valid = (r >= 2) && (c >= 2);
            end else if (win_ready) begin
                exp_valid = 1'b0;
            end
            held      = win_valid && !win_ready;
            held_data = win_data;
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && idx >= abort_after) return;
            if (done_cnt > 0) break;
        end
        frame_start = 1'b0; pix_valid = 1'b0; win_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("idle_frame_done", frame_done, 1'b0);
            chk("idle_win_valid", win_valid, 1'b0);
            chk("idle_pix_ready", pix_ready, 1'b0);
            @(negedge clk);
        end
        chk("frame_done_count", done_cnt, 1);
        chk("windows_left", exp_q.size(), 0);
        chk("window_count", nwin, TOTAL);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pix_ready"},  pix_ready,  1'b0);
        chk({tag, "_win_valid"},  win_valid,  1'b0);
        chk({tag, "_win_data"},   win_data,   72'h0);
        chk({tag, "_win_row"},    win_row,    3'd0);
        chk({tag, "_win_col"},    win_col,    3'd0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    vec_t        vecs [4];
    int          nwin;
    logic [71:0] fw, lw;

    initial begin
        vecs[0] = '{"basic",     0, 0, 0, 1'b0, 9, 72'h000102101112202122, 72'h222324323334424344};
        vecs[1] = '{"stall4",    0, 0, 4, 1'b0, 9, 72'h000102101112202122, 72'h222324323334424344};
        vecs[2] = '{"toggle",    1, 0, 0, 1'b0, 9, 72'h000102101112202122, 72'h222324323334424344};
        vecs[3] = '{"mid_start", 0, 0, 0, 1'b1, 9, 72'h000102101112202122, 72'h222324323334424344};

        rst_n = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            fill_pattern();
            run_frame(vecs[i].vmode, vecs[i].rmode, vecs[i].stall, vecs[i].mid, -1, nwin, fw, lw);
            chk({vecs[i].name, "_count"}, nwin, vecs[i].exp_n);
            chk({vecs[i].name, "_first"}, fw, vecs[i].exp_first);
            chk({vecs[i].name, "_last"},  lw, vecs[i].exp_last);
        end

        // Reset after 13 pixels: the (2,2) window is pending when reset hits.
        fill_pattern();
        run_frame(0, 0, 0, 1'b0, 13, nwin, fw, lw);
        pix_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        fill_pattern();
        run_frame(0, 0, 0, 1'b0, -1, nwin, fw, lw);
        chk("after_reset_first", fw, 72'h000102101112202122);
        chk("after_reset_last",  lw, 72'h222324323334424344);

        // Back-to-back frames with different content, then randomized traffic.
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++)
                        img[r][c] = ~{r[3:0], c[3:0]};
            end else begin
                fill_random();
            end
            run_frame(2, 1, i % 3, i[0], -1, nwin, fw, lw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
